// File: rtl/z16_instr_ram.sv
// ----------------------------------------------------------------------------
// z16_instr_ram
// ----------------------------------------------------------------------------
// Clocked instruction memory for the Z16 core. It replaces the older fixed
// combinational ROM.
//
// After reset the block runs a boot clear. For DEPTH cycles it writes
// FILL_INSTR into every word, one word per cycle starting at index 0. It then
// enters RUN, raises o_ready, and starts serving the fetch and program-load
// ports.
//
// Both ports use byte addresses. The word index is addr[ADDR_WIDTH-1:1].
//
// Optional feature (macro Z16_IMEM_MISALIGN_TRAP_EN):
//   - Adds the output o_misalign.
//   - Odd fetch addresses return FILL_INSTR with o_misalign=1.
//   - Odd write addresses are dropped with o_wr_err=1.
//   Without the macro, bit 0 of both addresses is ignored.
//
// Ports
//   i_clk       clock, all state changes on the rising edge
//   i_rst       synchronous active-high reset; restarts the clear sequence
//   i_rd_en     fetch request
//   i_addr      fetch byte address
//   o_instr     fetched instruction (registered, 1-cycle latency)
//   o_valid     o_instr was updated by a fetch this cycle
//   o_oob       fetch index was >= DEPTH; o_instr = FILL_INSTR
//   i_wr_en     program-load write request
//   i_wr_addr   write byte address
//   i_wr_data   write data
//   o_wr_ack    1-cycle pulse: write committed
//   o_wr_err    1-cycle pulse: write dropped
//   o_ready     clear sequence finished, ports are live
//   o_misalign  (macro only) last fetch used an odd byte address
// ----------------------------------------------------------------------------
module z16_instr_ram #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DEPTH      = 64,
    parameter logic [DATA_WIDTH-1:0] FILL_INSTR = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [DATA_WIDTH-1:0] o_instr,
    output logic                  o_valid,
    output logic                  o_oob,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_wr_ack,
    output logic                  o_wr_err,
`ifdef Z16_IMEM_MISALIGN_TRAP_EN
    output logic                  o_misalign,
`endif
    output logic                  o_ready
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // DEPTH can equal 2**(ADDR_WIDTH-1). That value does not fit in the
    // (ADDR_WIDTH-1)-bit index, so range checks are done one bit wider.
    localparam logic [ADDR_WIDTH-1:0] DEPTH_W  = ADDR_WIDTH'(DEPTH);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Storage and registers
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    state_t                r_state;
    logic [IDX_W-1:0]      r_clr_cnt;
    logic [DATA_WIDTH-1:0] r_instr;
    logic                  r_valid;
    logic                  r_oob;
    logic                  r_wr_ack;
    logic                  r_wr_err;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-2:0] w_rd_idx;
    logic [ADDR_WIDTH-2:0] w_wr_idx;
    logic                  w_rd_in_range;
    logic                  w_wr_in_range;
    logic                  w_rd_misalign;
    logic                  w_wr_misalign;

    assign w_rd_idx      = i_addr[ADDR_WIDTH-1:1];
    assign w_wr_idx      = i_wr_addr[ADDR_WIDTH-1:1];
    assign w_rd_in_range = ({1'b0, w_rd_idx} < DEPTH_W);
    assign w_wr_in_range = ({1'b0, w_wr_idx} < DEPTH_W);

`ifdef Z16_IMEM_MISALIGN_TRAP_EN
    assign w_rd_misalign = i_addr[0];
    assign w_wr_misalign = i_wr_addr[0];
`else
    // Byte-lane bits have no function in this build.
    logic w_unused_lsb;

    assign w_unused_lsb  = i_addr[0] ^ i_wr_addr[0];
    assign w_rd_misalign = 1'b0;
    assign w_wr_misalign = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state / control
    // ------------------------------------------------------------------
    state_t                w_state_next;
    logic [IDX_W-1:0]      w_clr_cnt_next;
    logic                  w_mem_we;
    logic [IDX_W-1:0]      w_mem_waddr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic                  w_rd_mem;      // fetch returns an array word
    logic                  w_valid_next;
    logic                  w_oob_next;
    logic                  w_ack_next;
    logic                  w_err_next;
    logic                  w_misalign_next;

    always_comb begin
        w_state_next    = r_state;
        w_clr_cnt_next  = r_clr_cnt;
        w_mem_we        = 1'b0;
        w_mem_waddr     = r_clr_cnt;
        w_mem_wdata     = FILL_INSTR;
        w_rd_mem        = 1'b0;
        w_valid_next    = 1'b0;
        w_oob_next      = 1'b0;
        w_ack_next      = 1'b0;
        w_err_next      = 1'b0;
        w_misalign_next = 1'b0;

        case (r_state)
            ST_CLEAR: begin
                // Port requests are ignored while the array is being filled.
                w_mem_we = 1'b1;
                if (r_clr_cnt == LAST_IDX) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_clr_cnt_next = r_clr_cnt + IDX_W'(1);
                end
            end

            ST_RUN: begin
                if (i_rd_en) begin
                    w_valid_next    = 1'b1;
                    w_oob_next      = !w_rd_in_range;
                    w_misalign_next = w_rd_misalign;
                    w_rd_mem        = w_rd_in_range && !w_rd_misalign;
                end

                if (i_wr_en) begin
                    if (w_wr_in_range && !w_wr_misalign) begin
                        w_mem_we    = 1'b1;
                        w_mem_waddr = w_wr_idx[IDX_W-1:0];
                        w_mem_wdata = i_wr_data;
                        w_ack_next  = 1'b1;
                    end else begin
                        w_err_next = 1'b1;
                    end
                end
            end

            default: begin
                w_state_next = ST_CLEAR;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_cnt <= w_clr_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Array write port
    // ------------------------------------------------------------------
    // Nothing is written in a reset cycle, so a write presented together
    // with i_rst is discarded.
    always_ff @(posedge i_clk) begin
        if (w_mem_we && !i_rst) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Registered read port and status pulses
    // ------------------------------------------------------------------
    // The read samples the array before this edge's write lands. A read and
    // a write to the same word in one cycle therefore return the old word.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_instr  <= '0;
            r_valid  <= 1'b0;
            r_oob    <= 1'b0;
            r_wr_ack <= 1'b0;
            r_wr_err <= 1'b0;
        end else begin
            r_valid  <= w_valid_next;
            r_oob    <= w_oob_next;
            r_wr_ack <= w_ack_next;
            r_wr_err <= w_err_next;
            if (w_valid_next) begin
                r_instr <= w_rd_mem ? r_mem[w_rd_idx[IDX_W-1:0]] : FILL_INSTR;
            end
        end
    end

`ifdef Z16_IMEM_MISALIGN_TRAP_EN
    logic r_misalign;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_misalign_next;
        end
    end

    assign o_misalign = r_misalign;
`endif

    assign o_instr  = r_instr;
    assign o_valid  = r_valid;
    assign o_oob    = r_oob;
    assign o_wr_ack = r_wr_ack;
    assign o_wr_err = r_wr_err;
    assign o_ready  = (r_state == ST_RUN);

endmodule

// File: tb/tb_z16_instr_ram.sv
// ----------------------------------------------------------------------------
// tb_z16_instr_ram
// ----------------------------------------------------------------------------
// Directed self-checking bench for z16_instr_ram with default parameters
// (DEPTH=64, FILL_INSTR=0).
//
// Inputs are driven on the falling edge. Outputs are sampled on the falling
// edge that follows the active rising edge.
// ----------------------------------------------------------------------------
module tb_z16_instr_ram;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic [15:0] addr;
    logic [15:0] instr;
    logic        valid;
    logic        oob;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_ack;
    logic        wr_err;
    logic        ready;
`ifdef Z16_IMEM_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    z16_instr_ram #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (16),
        .DEPTH      (64),
        .FILL_INSTR (16'h0000)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_rd_en    (rd_en),
        .i_addr     (addr),
        .o_instr    (instr),
        .o_valid    (valid),
        .o_oob      (oob),
        .i_wr_en    (wr_en),
        .i_wr_addr  (wr_addr),
        .i_wr_data  (wr_data),
        .o_wr_ack   (wr_ack),
        .o_wr_err   (wr_err),
`ifdef Z16_IMEM_MISALIGN_TRAP_EN
        .o_misalign (misalign),
`endif
        .o_ready    (ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Holds reset for ncyc rising edges, then releases it on a falling edge.
    task automatic do_reset(input int ncyc);
        @(negedge clk);
        rst = 1'b1;
        repeat (ncyc) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Counts the cycles with o_ready low after reset release. Both request
    // inputs stay high throughout, so any valid/ack/err pulse seen during
    // the clear is counted as a leak.
    task automatic wait_clear(output int n_cycles, output int n_pulses);
        n_cycles = 0;
        n_pulses = 0;
        rd_en    = 1'b1;
        addr     = 16'h0000;
        wr_en    = 1'b1;
        wr_addr  = 16'h0000;
        wr_data  = 16'hDEAD;
        for (int i = 0; i < 200; i++) begin
            if (ready) break;
            n_cycles++;
            if (valid || wr_ack || wr_err) n_pulses++;
            @(posedge clk);
            @(negedge clk);
        end
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic fetch(input logic [15:0] a, input logic [15:0] exp_instr, input logic exp_oob);
        rd_en = 1'b1;
        addr  = a;
        @(posedge clk);
        @(negedge clk);
        rd_en = 1'b0;
        chk($sformatf("fetch %04h valid", a), 32'(valid), 32'd1);
        chk($sformatf("fetch %04h instr", a), 32'(instr), 32'(exp_instr));
        chk($sformatf("fetch %04h oob", a), 32'(oob), 32'(exp_oob));
    endtask

    task automatic write(input logic [15:0] a, input logic [15:0] d,
                         input logic exp_ack, input logic exp_err);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        chk($sformatf("write %04h ack", a), 32'(wr_ack), 32'(exp_ack));
        chk($sformatf("write %04h err", a), 32'(wr_err), 32'(exp_err));
    endtask

    logic [15:0] prog [7];
    int          n_cyc;
    int          n_pls;

    initial begin
        prog[0] = 16'h0010;
        prog[1] = 16'h0020;
        prog[2] = 16'h0A19;
        prog[3] = 16'h1220;
        prog[4] = 16'hFF19;
        prog[5] = 16'hFC4F;
        prog[6] = 16'h00FD;

        rst     = 1'b1;
        rd_en   = 1'b0;
        addr    = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;

        // ---------------- reset state and boot clear ----------------
        do_reset(2);
        chk("reset ready", 32'(ready), 32'd0);
        chk("reset valid", 32'(valid), 32'd0);
        chk("reset instr", 32'(instr), 32'd0);
        chk("reset ack",   32'(wr_ack), 32'd0);
`ifdef Z16_IMEM_MISALIGN_TRAP_EN
        chk("reset misalign", 32'(misalign), 32'd0);
`endif
        wait_clear(n_cyc, n_pls);
        chk("clear cycles", 32'(n_cyc), 32'd64);
        chk("clear pulses", 32'(n_pls), 32'd0);
        chk("ready after clear", 32'(ready), 32'd1);

        // Every word reads FILL_INSTR. Index 0 also proves the write that
        // was held during the clear did not land.
        for (int i = 0; i < 64; i++) begin
            fetch(16'(2 * i), 16'h0000, 1'b0);
        end

        // ---------------- program load ----------------
        for (int i = 0; i < 7; i++) begin
            write(16'(2 * i), prog[i], 1'b1, 1'b0);
        end
        fetch(16'h0006, 16'h1220, 1'b0);
        fetch(16'h000C, 16'h00FD, 1'b0);

        // An idle cycle drops valid and holds the last instruction.
        @(posedge clk);
        @(negedge clk);
        chk("idle valid", 32'(valid), 32'd0);
        chk("idle instr hold", 32'(instr), 32'h00FD);

        // ---------------- out of range ----------------
        fetch(16'h0080, 16'h0000, 1'b1);
        fetch(16'h007E, 16'h0000, 1'b0);
        write(16'h0080, 16'h1234, 1'b0, 1'b1);

        // ---------------- same-cycle read and write ----------------
        rd_en   = 1'b1;
        addr    = 16'h0004;
        wr_en   = 1'b1;
        wr_addr = 16'h0004;
        wr_data = 16'hBEEF;
        @(posedge clk);
        @(negedge clk);
        rd_en = 1'b0;
        wr_en = 1'b0;
        chk("rw same old word", 32'(instr), 32'h0A19);
        chk("rw same ack", 32'(wr_ack), 32'd1);
        fetch(16'h0004, 16'hBEEF, 1'b0);

        // ---------------- byte-lane bit handling ----------------
`ifdef Z16_IMEM_MISALIGN_TRAP_EN
        fetch(16'h0005, 16'h0000, 1'b0);
        chk("misalign fetch flag", 32'(misalign), 32'd1);
        write(16'h0003, 16'h5555, 1'b0, 1'b1);
        fetch(16'h0002, 16'h0020, 1'b0);
        chk("aligned fetch misalign", 32'(misalign), 32'd0);
`else
        fetch(16'h0007, 16'h1220, 1'b0);
        write(16'h0003, 16'h5555, 1'b1, 1'b0);
        fetch(16'h0002, 16'h5555, 1'b0);
`endif

        // ---------------- reset in RUN, then again mid-clear ----------------
        fetch(16'h0004, 16'hBEEF, 1'b0);
        do_reset(1);
        chk("run reset ready", 32'(ready), 32'd0);
        chk("run reset instr", 32'(instr), 32'd0);
        chk("run reset valid", 32'(valid), 32'd0);
        repeat (10) @(posedge clk);
        do_reset(1);
        chk("midclear reset ready", 32'(ready), 32'd0);
        wait_clear(n_cyc, n_pls);
        chk("reclear cycles", 32'(n_cyc), 32'd64);
        chk("reclear pulses", 32'(n_pls), 32'd0);
        fetch(16'h0006, 16'h0000, 1'b0);
        fetch(16'h0004, 16'h0000, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
